// File: rtl/adder_arbiter.sv
// adder_arbiter
// Packet-granular round-robin arbiter that shares one external combinational
// adder between two flit-stream requesters. The selected operands are
// registered onto the adder inputs (stage 1). The sum is then registered,
// together with its source tag and last flag, into the result register.
//
// Handshake rule for every port: a transfer happens at a rising clk edge
// where valid and ready are both 1. The valid side holds its payload stable
// until that edge. The ready side may raise or drop ready at any time.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_* / req1_*             requester flit ports (valid/ready, op1, op2, last)
//   add_in1, add_in2            registered operands driving the external adder
//   add_sum                     combinational sum returned by the adder
//   res_valid/res_ready         result port handshake
//   res_data/res_src/res_last   result payload
//   busy_cnt                    cycles spent in a grant state, saturating
//   flit_cnt0/flit_cnt1         accepted flits per requester, saturating
//   fsm_state                   current arbiter state, for observation
module adder_arbiter #(
  parameter int N     = 13,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [N-1:0]     req0_op1,
  input  logic [N-1:0]     req0_op2,
  input  logic             req0_last,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [N-1:0]     req1_op1,
  input  logic [N-1:0]     req1_op2,
  input  logic             req1_last,
  output logic [N-1:0]     add_in1,
  output logic [N-1:0]     add_in2,
  input  logic [N-1:0]     add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_src,
  output logic             res_last,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] flit_cnt0,
  output logic [CNT_W-1:0] flit_cnt1,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;

  logic   s1_valid;
  logic   s1_src;
  logic   s1_last;
  logic   s1_adv;
  logic   acc0, acc1, acc_any;

  // Stage 1 may hand over its flit when the result register is free or is
  // being drained in the same cycle.
  assign s1_adv  = s1_valid & (~res_valid | res_ready);
  assign acc0    = req0_valid & req0_ready;
  assign acc1    = req1_valid & req1_ready;
  assign acc_any = acc0 | acc1;

  assign fsm_state = state;

  // Next-state, pointer and ready logic. The grant is held until the last
  // flit of the packet is accepted, so packets are never interleaved.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_nxt = ptr ? GRANT1 : GRANT0;
        else if (req0_valid)          state_nxt = GRANT0;
        else if (req1_valid)          state_nxt = GRANT1;
      end
      GRANT0: begin
        req0_ready = ~s1_valid | s1_adv;
        if (req0_valid && req0_ready && req0_last) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      GRANT1: begin
        req1_ready = ~s1_valid | s1_adv;
        if (req1_valid && req1_ready && req1_last) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Stage 1: the adder inputs change only on an accepted flit. Otherwise they
  // keep their previous operands so the adder sees no toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_in1  <= '0;
      add_in2  <= '0;
      s1_src   <= 1'b0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
    end else if (acc_any) begin
      add_in1  <= acc1 ? req1_op1 : req0_op1;
      add_in2  <= acc1 ? req1_op2 : req0_op2;
      s1_src   <= acc1;
      s1_last  <= acc1 ? req1_last : req0_last;
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register: loads on advance; otherwise the payload stays frozen and
  // valid clears once the downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_src   <= 1'b0;
      res_last  <= 1'b0;
    end else if (s1_adv) begin
      res_valid <= 1'b1;
      res_data  <= add_sum;
      res_src   <= s1_src;
      res_last  <= s1_last;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt  <= '0;
      flit_cnt0 <= '0;
      flit_cnt1 <= '0;
    end else begin
      if ((state == GRANT0 || state == GRANT1) && busy_cnt != '1)
        busy_cnt <= busy_cnt + CNT_W'(1);
      if (acc0 && flit_cnt0 != '1)
        flit_cnt0 <= flit_cnt0 + CNT_W'(1);
      if (acc1 && flit_cnt1 != '1)
        flit_cnt1 <= flit_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter. Two instances share all inputs: the main one
// has 16-bit counters and the second has 4-bit counters for saturation.
module tb_adder_arbiter;
  localparam int N     = 13;
  localparam int CNT_W = 16;
  localparam int SAT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             req0_valid, req0_ready, req0_last;
  logic [N-1:0]     req0_op1, req0_op2;
  logic             req1_valid, req1_ready, req1_last;
  logic [N-1:0]     req1_op1, req1_op2;
  logic [N-1:0]     add_in1, add_in2, add_sum;
  logic             res_valid, res_ready, res_src, res_last;
  logic [N-1:0]     res_data;
  logic [CNT_W-1:0] busy_cnt, flit_cnt0, flit_cnt1;
  logic [1:0]       fsm_state;

  logic             s_req0_ready, s_req1_ready, s_res_valid, s_res_src, s_res_last;
  logic [N-1:0]     s_add_in1, s_add_in2, s_add_sum, s_res_data;
  logic [SAT_W-1:0] s_busy_cnt, s_flit_cnt0, s_flit_cnt1;
  logic [1:0]       s_fsm_state;

  // External combinational adder: carry-out is dropped.
  assign add_sum   = add_in1 + add_in2;
  assign s_add_sum = s_add_in1 + s_add_in2;

  adder_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_last(req1_last),
    .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_last(res_last),
    .busy_cnt(busy_cnt), .flit_cnt0(flit_cnt0), .flit_cnt1(flit_cnt1),
    .fsm_state(fsm_state)
  );

  adder_arbiter #(.N(N), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_last(req1_last),
    .add_in1(s_add_in1), .add_in2(s_add_in2), .add_sum(s_add_sum),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
    .res_src(s_res_src), .res_last(s_res_last),
    .busy_cnt(s_busy_cnt), .flit_cnt0(s_flit_cnt0), .flit_cnt1(s_flit_cnt1),
    .fsm_state(s_fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  // Entry layout: {src, last, sum}
  logic [N+1:0] exp_q[$];
  logic [N+1:0] obs_q[$];
  int           acc_cyc0[$];
  int           acc_cyc1[$];
  int           acc_cnt0 = 0;
  int           acc_cnt1 = 0;
  int           add_in_err = 0;
  int           stab_err = 0;
  logic         prev_hold = 1'b0;
  logic [N+1:0] h_res = '0;
  logic [N-1:0] last_op1 = '0;
  logic [N-1:0] last_op2 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge. It collects results and checks two
  // invariants. A held result must not change. The adder inputs must always
  // show the operands of the most recently accepted flit.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold <= 1'b0;
      last_op1  <= '0;
      last_op2  <= '0;
    end else begin
      if (res_valid && res_ready) obs_q.push_back({res_src, res_last, res_data});
      if (prev_hold && {res_src, res_last, res_data} !== h_res) stab_err <= stab_err + 1;
      prev_hold <= res_valid && !res_ready;
      h_res     <= {res_src, res_last, res_data};
      if ({add_in1, add_in2} !== {last_op1, last_op2}) add_in_err <= add_in_err + 1;
      if (req0_valid && req0_ready) begin
        acc_cnt0 <= acc_cnt0 + 1;
        last_op1 <= req0_op1;
        last_op2 <= req0_op2;
      end else if (req1_valid && req1_ready) begin
        acc_cnt1 <= acc_cnt1 + 1;
        last_op1 <= req1_op1;
        last_op2 <= req1_op2;
      end
    end
  end

  // Reference: modular sum computed with plain integer arithmetic.
  function automatic logic [N-1:0] model_sum(input logic [N-1:0] a, input logic [N-1:0] b);
    int s;
    s = (int'(a) + int'(b)) % (1 << N);
    return N'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_flit(input int src, input logic [N-1:0] op1,
                           input logic [N-1:0] op2, input logic last);
    bit   done = 1'b0;
    int   t = 0;
    logic s;
    logic rdy;
    s = src[0];
    if (s == 1'b0) begin
      req0_valid = 1'b1; req0_op1 = op1; req0_op2 = op2; req0_last = last;
    end else begin
      req1_valid = 1'b1; req1_op1 = op1; req1_op2 = op2; req1_last = last;
    end
    while (!done && t < 300) begin
      @(negedge clk);
      rdy = (s == 1'b0) ? req0_ready : req1_ready;
      if (rdy) begin
        done = 1'b1;
        exp_q.push_back({s, last, model_sum(op1, op2)});
        if (s == 1'b0) acc_cyc0.push_back(cyc);
        else           acc_cyc1.push_back(cyc);
      end
      @(posedge clk); #1;
      t++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL send_flit_timeout src=%0d got=no_accept want=accept", src);
    end
  endtask

  task automatic send_pkt(input int src, input int len);
    logic [N-1:0] a, b;
    for (int i = 0; i < len; i++) begin
      a = N'($urandom_range(0, (1 << N) - 1));
      b = N'($urandom_range(0, (1 << N) - 1));
      send_flit(src, a, b, i == len - 1);
    end
    if (src == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_q.delete(); obs_q.delete(); acc_cyc0.delete(); acc_cyc1.delete();
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_sb();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [N-1:0] zero_n = '0;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_op1 = '0; req0_op2 = '0; req0_last = 1'b0;
    req1_op1 = '0; req1_op2 = '0; req1_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({res_valid, res_data, add_in1, add_in2, busy_cnt, flit_cnt0, fsm_state} !== '0) begin
      bad++;
      $display("FAIL reset_init got=%0h/%0h/%0h/%0h want=0", res_valid, res_data, add_in1, busy_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_sb();
    // Pile two flits of an unfinished packet into the pipeline.
    req0_valid = 1'b1; req0_op1 = 13'h0123; req0_op2 = 13'h0456; req0_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (res_valid !== 1'b1 || res_data !== 13'h0579) begin
      bad++;
      $display("FAIL reset_prefill got=%0b/%0h want=1/579", res_valid, res_data);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({res_valid, res_data, res_src, res_last, add_in1, add_in2} !== {1'b0, zero_n, 1'b0, 1'b0, zero_n, zero_n}) begin
      bad++;
      $display("FAIL reset_async_regs got=%0b/%0h/%0h/%0h want=0", res_valid, res_data, add_in1, add_in2);
    end
    total++;
    if ({busy_cnt, flit_cnt0, flit_cnt1, fsm_state, req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL reset_async_cnt got=%0d/%0d/%0d/%0d/%0b want=0", busy_cnt, flit_cnt0, flit_cnt1, fsm_state, req0_ready);
    end
    req0_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_sb();
    // After release the pointer favours requester 0.
    res_ready = 1'b1;
    fork
      send_pkt(0, 1);
      send_pkt(1, 1);
    join
    wait_drain();
    total++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[0][N+1] !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant got=%0h want=%0h (src0)", obs_q[0], exp_q[0]);
    end
    total++;
    if (obs_q[1] !== exp_q[1] || obs_q[1][N+1] !== 1'b1) begin
      bad++;
      $display("FAIL reset_second_grant got=%0h want=%0h (src1)", obs_q[1], exp_q[1]);
    end
  endtask

  task automatic test_single();
    bit found = 1'b0;
    int t = 0;
    clear_sb();
    res_ready  = 1'b1;
    req0_valid = 1'b1; req0_op1 = 13'h0FFF; req0_op2 = 13'h1FFF; req0_last = 1'b1;
    while (!found && t < 20) begin
      @(negedge clk);
      found = req0_ready;
      @(posedge clk); #1;
      t++;
    end
    req0_valid = 1'b0;
    total++;
    if (!found || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got=%0b/%0b want=1/0", found, res_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({res_valid, res_data, res_src, res_last} !== {1'b1, 13'h0FFE, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL single_result got=%0b/%0h/%0b/%0b want=1/ffe/0/1", res_valid, res_data, res_src, res_last);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    clear_sb();
    res_ready = 1'b1;
    send_flit(0, 13'h1FFF, 13'h0001, 1'b0);
    send_flit(0, 13'h1FFF, 13'h1FFF, 1'b1);
    req0_valid = 1'b0;
    wait_drain();
    total++;
    if (obs_q.size() != 2 || obs_q[0] !== {1'b0, 1'b0, 13'h0000}) begin
      bad++;
      $display("FAIL wrap_zero got=%0h want=%0h", obs_q[0], {1'b0, 1'b0, 13'h0000});
    end
    total++;
    if (obs_q[1] !== {1'b0, 1'b1, 13'h1FFE}) begin
      bad++;
      $display("FAIL wrap_max got=%0h want=%0h", obs_q[1], {1'b0, 1'b1, 13'h1FFE});
    end
  endtask

  task automatic test_contention();
    int ai0, se0, errs;
    do_reset();
    ai0 = add_in_err; se0 = stab_err; errs = 0;
    res_ready = 1'b1;
    fork
      send_pkt(0, 20);
      send_pkt(1, 20);
    join
    wait_drain();
    total++;
    if (obs_q.size() != 40) begin
      bad++;
      $display("FAIL cont_count got=%0d want=40", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 40; i++) begin
      total++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][N+1] !== (i >= 20)) begin
        bad++;
        $display("FAIL cont_flit_%0d got=%0h want=%0h", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (acc_cyc1.size() < 1 || acc_cyc0.size() < 20 || acc_cyc1[0] - acc_cyc0[19] != 2) begin
      bad++;
      $display("FAIL cont_idle_gap got=%0d want=2", acc_cyc1[0] - acc_cyc0[19]);
    end
    total++;
    if (busy_cnt !== 16'd40 || flit_cnt0 !== 16'd20 || flit_cnt1 !== 16'd20) begin
      bad++;
      $display("FAIL cont_counters got=%0d/%0d/%0d want=40/20/20", busy_cnt, flit_cnt0, flit_cnt1);
    end
    total++;
    if (s_busy_cnt !== 4'd15 || s_flit_cnt0 !== 4'd15 || s_flit_cnt1 !== 4'd15) begin
      bad++;
      $display("FAIL cont_sat got=%0d/%0d/%0d want=15/15/15", s_busy_cnt, s_flit_cnt0, s_flit_cnt1);
    end
    total++;
    if (add_in_err != ai0 || stab_err != se0) begin
      bad++;
      $display("FAIL cont_hold got=%0d/%0d want=0/0", add_in_err - ai0, stab_err - se0);
    end
  endtask

  task automatic test_backpressure();
    int a0, se0;
    clear_sb();
    se0 = stab_err;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      send_flit(0, N'($urandom_range(0, 8191)), N'($urandom_range(0, 8191)), 1'b0);
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    res_ready = 1'b0;
    a0 = acc_cnt0;
    fork
      begin
        for (int i = 8; i < 20; i++)
          send_flit(0, N'($urandom_range(0, 8191)), N'($urandom_range(0, 8191)), i == 19);
        req0_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (acc_cnt0 - a0 != 2) begin
          bad++;
          $display("FAIL bp_accepts got=%0d want=2", acc_cnt0 - a0);
        end
        total++;
        if (res_valid !== 1'b1 || exp_q.size() < 9 || res_data !== exp_q[8][N-1:0] || req0_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_hold got=%0b/%0h/%0b want=1/%0h/0", res_valid, res_data, req0_ready, exp_q[8][N-1:0]);
        end
        res_ready = 1'b1;
      end
    join
    wait_drain();
    total++;
    if (obs_q.size() != 20 || obs_q != exp_q) begin
      bad++;
      $display("FAIL bp_order got=%0d want=20 (in order)", obs_q.size());
    end
    total++;
    if (stab_err != se0) begin
      bad++;
      $display("FAIL bp_stable got=%0d want=0", stab_err - se0);
    end
  endtask

  task automatic test_random();
    int n0, errs, ai0, se0;
    do_reset();
    ai0 = add_in_err; se0 = stab_err;
    fork
      begin
        repeat (4) send_pkt(0, int'($urandom_range(1, 8)));
      end
      begin
        repeat (4) send_pkt(1, int'($urandom_range(1, 8)));
      end
      begin
        repeat (300) begin
          res_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        res_ready = 1'b1;
      end
    join
    wait_drain();
    errs = 0;
    n0 = 0;
    foreach (exp_q[i]) if (exp_q[i][N+1] == 1'b0) n0++;
    total++;
    if (obs_q != exp_q) begin
      bad++;
      $display("FAIL rand_results got=%0d want=%0d (entries in order)", obs_q.size(), exp_q.size());
    end
    // A source may only change right after a last flit.
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i-1][N] == 1'b0 && obs_q[i][N+1] != obs_q[i-1][N+1]) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL rand_interleave got=%0d want=0", errs);
    end
    total++;
    if (int'(flit_cnt0) != n0 || int'(flit_cnt1) != exp_q.size() - n0) begin
      bad++;
      $display("FAIL rand_flit_cnt got=%0d/%0d want=%0d/%0d", flit_cnt0, flit_cnt1, n0, exp_q.size() - n0);
    end
    total++;
    if (add_in_err != ai0 || stab_err != se0) begin
      bad++;
      $display("FAIL rand_hold got=%0d/%0d want=0/0", add_in_err - ai0, stab_err - se0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    res_ready = 1'b1;
    send_pkt(0, 20);
    wait_drain();
    total++;
    if (s_flit_cnt0 !== 4'd15 || s_busy_cnt !== 4'd15 || s_flit_cnt1 !== 4'd0) begin
      bad++;
      $display("FAIL sat_counters got=%0d/%0d/%0d want=15/15/0", s_flit_cnt0, s_busy_cnt, s_flit_cnt1);
    end
    total++;
    if (flit_cnt0 !== 16'd20 || busy_cnt !== 16'd20) begin
      bad++;
      $display("FAIL sat_wide got=%0d/%0d want=20/20", flit_cnt0, busy_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Packet-granular round-robin arbiter and sequencer that shares one combinational N-bit `adder` between two flit-stream requesters. It registers the selected operands onto the adder inputs and registers the sum with a source tag. Adder inputs are held steady whenever no new flit is issued. Activity counters support the energy-characterization flow. It sits between two packet sources (20-flit payload typical) and one `adder` instance, with a valid/ready result port downstream.

## Interface
- N, 13, operand/sum width (matches `adder`)
- CNT_W, 16, width of activity counters
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  flit offered by requester 0 / 1
- req0_ready / req1_ready  out  1  flit accepted when valid&ready at rising edge
- req0_op1, req0_op2 / req1_op1, req1_op2  in  N  operands of the flit
- req0_last / req1_last  in  1  flit is the last of its packet
- add_in1, add_in2  out  N  registered operands driving `adder.input1/input2`
- add_sum  in  N  `adder.sum`, combinational from add_in1/add_in2
- res_valid  out  1  result held in output register
- res_ready  in  1  downstream accepts result
- res_data  out  N  registered sum
- res_src  out  1  requester index of the result
- res_last  out  1  copy of the flit's last flag
- busy_cnt  out  CNT_W  cycles spent in a GRANT state, saturating
- flit_cnt0 / flit_cnt1  out  CNT_W  flits accepted per requester, saturating

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Round-robin pointer `ptr` (1 bit) names the favoured requester.
- IDLE: if exactly one reqX_valid is high, go to GRANTX. If both are high, go to GRANT[ptr]. If neither, stay. Ready signals are 0 in IDLE.
- GRANTX: reqX_ready = !s1_valid | s1_adv. The other ready is 0. An accepted flit with reqX_last=1 sends the FSM to IDLE and sets ptr = ~X. Otherwise the FSM stays in GRANTX; a packet is never interleaved.
- Stage 1 (operand register): on acceptance, add_in1<=op1, add_in2<=op2, s1_src<=X, s1_last<=last, s1_valid<=1.
  - When no flit is accepted, add_in1/add_in2 hold their value; they never return to 0, so the adder sees no toggling.
- s1_adv = s1_valid & (!res_valid | res_ready).
- On s1_adv: res_data<=add_sum, res_src<=s1_src, res_last<=s1_last, res_valid<=1. s1_valid clears unless a new flit is accepted in the same cycle.
- res_valid clears on res_valid&res_ready when there is no simultaneous s1_adv.
- Arithmetic: sum = (op1+op2) mod 2^N; carry-out is discarded.
- busy_cnt += 1 each cycle the state is GRANT0/GRANT1. flit_cntX += 1 per accepted flit. All counters saturate at 2^CNT_W-1.
- Reset (async, any time, including mid-packet): state=IDLE, ptr=0, s1_valid=0, res_valid=0, add_in1/add_in2/res_data=0, res_src=0, res_last=0, all counters=0. In-flight flits are discarded. Requesters must re-send the whole packet.

## Timing
- Arbitration: a valid first seen in IDLE at edge e gives GRANT state after e, so ready is possible from the next cycle. There is exactly one IDLE cycle between packets.
- Latency: a handshake at edge k loads stage 1. Stage 1 moves to the output at edge k+1, so res_valid=1 after edge k+1 when the output is free.
- Throughput: 1 flit/cycle while res_ready=1.
- Backpressure: with res_ready=0, at most 2 flits are buffered (stage 1 + output), then reqX_ready=0.
  - res_data/res_src/res_last must stay stable while res_valid&!res_ready.
- Simultaneous accept, advance and drain in one cycle is legal and loses nothing.
- All outputs are registered except reqX_ready, which is combinational from state, s1_valid, res_valid and res_ready.

## Test plan
- Reset: rst_n=0 mid-stream -> all outputs 0 immediately (asynchronously). After release: IDLE, ptr=0, first grant goes to req0 when both are valid.
- Single flit req0: op1=0x0FFF, op2=0x1FFF, last=1 -> res_data=0x0FFE, res_src=0, res_last=1, res_valid one edge after the handshake edge.
- Wrap: op1=0x1FFF, op2=0x0001 -> res_data=0x0000. Then 0x1FFF+0x1FFF -> 0x1FFE.
- Contention: both requesters hold 20-flit packets, res_ready=1.
  - Required: 20 results with res_src=0, no interleave, then 20 with res_src=1, one idle cycle between packets.
  - Required: busy_cnt=40, flit_cnt0=flit_cnt1=20, add_in stable during the idle cycle.
- Backpressure: res_ready=0 for 5 cycles mid-packet -> exactly 2 further flits accepted, res_data constant, all 20 sums delivered in order after release.
- Saturation: CNT_W=4, one 20-flit packet -> flit_cnt0=15, busy_cnt=15.
